// File: rtl/hazard_controller.sv
// Stall/flush sequencing, E-stage operand forwarding and dmem wait FSM for the 5-stage pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_controller #(
    parameter int REG_ID_W    = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_ID_W-1:0] rs_D,
    input  logic [REG_ID_W-1:0] rt_D,
    input  logic [REG_ID_W-1:0] rs_E,
    input  logic [REG_ID_W-1:0] rt_E,
    input  logic [REG_ID_W-1:0] reg_id_E,
    input  logic [REG_ID_W-1:0] reg_id_M,
    input  logic [REG_ID_W-1:0] reg_id_W,
    input  logic                reg_write_E,
    input  logic                reg_write_M,
    input  logic                reg_write_W,
    input  logic                mem_to_reg_E,
    input  logic                mem_to_reg_M,
    input  logic                pc_src_M,
    input  logic                dmem_req_M,
    input  logic                dmem_ready,
    output logic                stall_F,
    output logic                stall_D,
    output logic                stall_E,
    output logic                stall_M,
    output logic                flush_D,
    output logic                flush_E,
    output logic                flush_M,
    output logic                flush_W,
    output logic [1:0]          fwdA_E,
    output logic [1:0]          fwdB_E,
    output logic                mem_wait,
    output logic                mem_err,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);
    localparam logic [REG_ID_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mem_err_q, mem_err_d;
    logic                load_use;
    logic                timeout_hit;
    logic                in_wait;

    // M result wins over W; a load in M has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_ID_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_write_M && (reg_id_M != REG_ZERO) && (reg_id_M == src) && !mem_to_reg_M)
            sel = 2'b10;
        else if (reg_write_W && (reg_id_W != REG_ZERO) && (reg_id_W == src))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_err_d   = mem_err_q;
        in_wait     = 1'b0;
        timeout_hit = (state_q == S_WAIT) && (wcnt_q == TIMEOUT_V);
        load_use    = mem_to_reg_E && reg_write_E && (reg_id_E != REG_ZERO) &&
                      ((reg_id_E == rs_D) || (reg_id_E == rt_D));

        case (state_q)
            S_RUN: begin
                wcnt_d = '0;
                if (dmem_req_M && !dmem_ready) begin
                    state_d = S_WAIT;
                    in_wait = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else if (timeout_hit) begin
                    // Forced release: the access is treated as complete this cycle.
                    state_d   = S_RUN;
                    wcnt_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                    in_wait = 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        flush_M  = 1'b0;
        flush_W  = 1'b0;
        mem_wait = 1'b0;
        fwdA_E   = 2'b00;
        fwdB_E   = 2'b00;
        mem_err  = mem_err_q && !reset;

        if (reset) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_M = 1'b1;
            flush_W = 1'b1;
        end else begin
            fwdA_E = fwd_sel(rs_E);
            fwdB_E = fwd_sel(rt_E);
            if (in_wait) begin
                stall_F  = 1'b1;
                stall_D  = 1'b1;
                stall_E  = 1'b1;
                stall_M  = 1'b1;
                flush_W  = 1'b1;
                mem_wait = 1'b1;
            end else if (pc_src_M) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
                flush_M = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_F || stall_D || stall_E || stall_M) && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if ((flush_D || flush_E || flush_M) && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: single-cycle vector table plus multi-cycle wait/timeout/reset sequences.
module tb_hazard_controller;

    localparam int RW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] rs_D, rt_D, rs_E, rt_E, reg_id_E, reg_id_M, reg_id_W;
    logic          reg_write_E, reg_write_M, reg_write_W;
    logic          mem_to_reg_E, mem_to_reg_M, pc_src_M, dmem_req_M, dmem_ready;
    logic          stall_F, stall_D, stall_E, stall_M;
    logic          flush_D, flush_E, flush_M, flush_W;
    logic [1:0]    fwdA_E, fwdB_E;
    logic          mem_wait, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_ID_W(RW), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .reg_id_E(reg_id_E), .reg_id_M(reg_id_M), .reg_id_W(reg_id_W),
        .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M),
        .pc_src_M(pc_src_M), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .mem_wait(mem_wait), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [RW-1:0] rs_D, rt_D, rs_E, rt_E, id_E, id_M, id_W;
        logic          rw_E, rw_M, rw_W, mtr_E, mtr_M, pc, req, rdy;
        logic [3:0]    e_stall;   // {F,D,E,M}
        logic [3:0]    e_flush;   // {D,E,M,W}
        logic [1:0]    e_a, e_b;
        logic          e_wait;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        {rs_D, rt_D, rs_E, rt_E, reg_id_E, reg_id_M, reg_id_W} = '0;
        {reg_write_E, reg_write_M, reg_write_W, mem_to_reg_E, mem_to_reg_M} = '0;
        {pc_src_M, dmem_req_M, dmem_ready} = '0;
    endtask

    task automatic apply(input vec_t v);
        rs_D = v.rs_D; rt_D = v.rt_D; rs_E = v.rs_E; rt_E = v.rt_E;
        reg_id_E = v.id_E; reg_id_M = v.id_M; reg_id_W = v.id_W;
        reg_write_E = v.rw_E; reg_write_M = v.rw_M; reg_write_W = v.rw_W;
        mem_to_reg_E = v.mtr_E; mem_to_reg_M = v.mtr_M;
        pc_src_M = v.pc; dmem_req_M = v.req; dmem_ready = v.rdy;
    endtask

    // Sample at negedge, compare control outputs, then advance to just after the next posedge.
    task automatic cyc(input string nm, input logic [3:0] s, input logic [3:0] f, input logic w);
        @(negedge clk);
        chk({nm, " stall"}, {28'd0, stall_F, stall_D, stall_E, stall_M}, {28'd0, s});
        chk({nm, " flush"}, {28'd0, flush_D, flush_E, flush_M, flush_W}, {28'd0, f});
        chk({nm, " mem_wait"}, {31'd0, mem_wait}, {31'd0, w});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_cycles;
        //          rs_D   rt_D   rs_E   rt_E   id_E   id_M   id_W   rwE  rwM  rwW  mtrE mtrM pc   req  rdy   stall    flush    a      b      wait
        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b10,2'b00,1'b0};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b01,2'b00,1'b0};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b01,2'b00,1'b0};
        vecs[3]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00,1'b0};
        vecs[4]  = '{5'd0, 5'd0, 5'd9, 5'd7, 5'd0, 5'd7, 5'd9, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b01,2'b10,1'b0};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00,1'b0};
        vecs[6]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b1100,4'b0100,2'b00,2'b00,1'b0};
        vecs[7]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b1100,4'b0100,2'b00,2'b00,1'b0};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00,1'b0};
        vecs[9]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00,1'b0};
        vecs[10] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00,1'b0};
        vecs[11] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 4'b0000,4'b1110,2'b00,2'b00,1'b0};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'b0000,4'b1110,2'b00,2'b00,1'b0};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 4'b0000,4'b0000,2'b00,2'b00,1'b0};
        vecs[14] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 4'b1100,4'b0100,2'b00,2'b00,1'b0};

        // Reset cycle, with forwarding-triggering inputs present
        idle();
        reset = 1'b1;
        rs_E = 5'd5; reg_id_M = 5'd5; reg_write_M = 1'b1;
        @(negedge clk);
        chk("reset fwdA", {30'd0, fwdA_E}, 32'd0);
        cyc("reset", 4'b0000, 4'b1111, 1'b0);
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("post-reset mem_err", {31'd0, mem_err}, 32'd0);
        chk("post-reset stall_cnt", stall_cnt, 32'd0);
        chk("post-reset flush_cnt", flush_cnt, 32'd0);
        cyc("post-reset", 4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d fwdA", i), {30'd0, fwdA_E}, {30'd0, vecs[i].e_a});
            chk($sformatf("vec%0d fwdB", i), {30'd0, fwdB_E}, {30'd0, vecs[i].e_b});
            @(posedge clk);
            #1;
            cyc($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_wait);
        end

        // Four-cycle memory wait
        idle();
        dmem_req_M = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("wait4 c%0d", i), 4'b1111, 4'b0001, 1'b1);
        dmem_ready = 1'b1;
        cyc("wait4 exit", 4'b0000, 4'b0000, 1'b0);
        idle();
        @(negedge clk);
        chk("wait4 mem_err", {31'd0, mem_err}, 32'd0);
        cyc("wait4 idle", 4'b0000, 4'b0000, 1'b0);

        // Branch and load-use held through a wait: suppressed until exit, branch wins there
        apply(vecs[11]);
        dmem_req_M = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("wait_br c%0d", i), 4'b1111, 4'b0001, 1'b1);
        dmem_ready = 1'b1;
        cyc("wait_br exit", 4'b0000, 4'b1110, 1'b0);
        idle();
        cyc("wait_br idle", 4'b0000, 4'b0000, 1'b0);

        // Timeout: dmem_ready never arrives
        dmem_req_M = 1'b1;
        wait_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_wait) break;
            wait_cycles++;
            @(posedge clk);
            #1;
        end
        chk("timeout wait cycles", wait_cycles, 32'd16);
        chk("timeout release stall", {28'd0, stall_F, stall_D, stall_E, stall_M}, 32'd0);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("timeout mem_err set", {31'd0, mem_err}, 32'd1);
        cyc("timeout after", 4'b0000, 4'b0000, 1'b0);
        cyc("timeout idle", 4'b0000, 4'b0000, 1'b0);
        dmem_req_M = 1'b1;
        cyc("err wait", 4'b1111, 4'b0001, 1'b1);
        dmem_ready = 1'b1;
        cyc("err exit", 4'b0000, 4'b0000, 1'b0);
        idle();
        @(negedge clk);
        chk("mem_err sticky", {31'd0, mem_err}, 32'd1);
`ifndef HAZARD_PERF_EN
        chk("stall_cnt disabled", stall_cnt, 32'd0);
        chk("flush_cnt disabled", flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Reset on the second wait cycle
        dmem_req_M = 1'b1;
        cyc("rstwait c0", 4'b1111, 4'b0001, 1'b1);
        reset = 1'b1;
        cyc("rstwait reset", 4'b0000, 4'b1111, 1'b0);
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rstwait mem_err", {31'd0, mem_err}, 32'd0);
        chk("rstwait stall_cnt", stall_cnt, 32'd0);
        chk("rstwait flush_cnt", flush_cnt, 32'd0);
        cyc("rstwait run", 4'b0000, 4'b0000, 1'b0);
        cyc("rstwait run2", 4'b0000, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
